// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state encoding and macro geometry for the SRAM port arbiter
package sram_ctrl_pkg;
  localparam int SRAM_ADDR_W = 9;
  localparam int SRAM_DATA_W = 32;
  localparam int SRAM_MASK_W = 4;
  localparam int SRAM_DEPTH  = 512;
  typedef enum logic [1:0] {RST_IDLE, INIT, RUN} state_e;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter, pointer moves only on contention
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);
  logic ptr_q, ptr_d;
  assign gnt_o[0] = en_i & valid0_i & (~valid1_i | ~ptr_q);
  assign gnt_o[1] = en_i & valid1_i & (~valid0_i | ptr_q);
  assign ptr_d = (en_i & valid0_i & valid1_i) ? ~ptr_q : ptr_q;
  // pointer register, req0 preferred out of reset
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: zero-fills the macro after reset, then round-robins two requesters onto port 0
module sram_port_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W  = SRAM_ADDR_W,
  parameter int DATA_W  = SRAM_DATA_W,
  parameter int MASK_W  = SRAM_MASK_W,
  parameter int DEPTH   = SRAM_DEPTH,
  parameter bit INIT_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [MASK_W-1:0] req0_wmask,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_gnt,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [MASK_W-1:0] req1_wmask,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_gnt,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              init_done,
  output logic              sram_csb0,
  output logic              sram_web0,
  output logic [MASK_W-1:0] sram_wmask0,
  output logic [ADDR_W-1:0] sram_addr0,
  output logic [DATA_W-1:0] sram_din0,
  input  logic [DATA_W-1:0] sram_dout0
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_done_q, init_done_d;
  logic              rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [1:0]        gnt;
  rr_arbiter2 u_arb (
    .clock    (clock),
    .reset_n  (reset_n),
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .en_i     (state_q == RUN),
    .gnt_o    (gnt)
  );
  assign req0_gnt   = gnt[0];
  assign req1_gnt   = gnt[1];
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rsp0_valid_q ? sram_dout0 : '0;
  assign rsp1_rdata = rsp1_valid_q ? sram_dout0 : '0;
  assign init_done  = init_done_q;
  // sequencing: idle cycle, optional fill sweep, then run; responses tag granted reads
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    init_done_d  = init_done_q;
    rsp0_valid_d = gnt[0] & ~req0_we;
    rsp1_valid_d = gnt[1] & ~req1_we;
    if (state_q == RST_IDLE) begin
      state_d     = INIT_EN ? INIT : RUN;
      init_done_d = !INIT_EN;
    end
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d     = RUN;
        init_done_d = 1'b1;
      end
    end
  end
  // macro port 0 drive: fill write, granted requester, or idle
  always_comb begin
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = '0;
    sram_addr0  = '0;
    sram_din0   = '0;
    if (state_q == INIT) begin
      sram_csb0   = 1'b0;
      sram_web0   = 1'b0;
      sram_wmask0 = '1;
      sram_addr0  = cnt_q;
    end else if (gnt[0]) begin
      sram_csb0   = 1'b0;
      sram_web0   = ~req0_we;
      sram_wmask0 = req0_wmask;
      sram_addr0  = req0_addr;
      sram_din0   = req0_wdata;
    end else if (gnt[1]) begin
      sram_csb0   = 1'b0;
      sram_web0   = ~req1_we;
      sram_wmask0 = req1_wmask;
      sram_addr0  = req1_addr;
      sram_din0   = req1_wdata;
    end
  end
  // state, fill counter and response flags; reset drops any pending response
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q      <= RST_IDLE;
      cnt_q        <= '0;
      init_done_q  <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      init_done_q  <= init_done_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed vector bench with a behavioural macro model
module tb_sram_port_arbiter;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid, req0_we, req1_valid, req1_we;
  logic [8:0]  req0_addr, req1_addr, sram_addr0;
  logic [3:0]  req0_wmask, req1_wmask, sram_wmask0;
  logic [31:0] req0_wdata, req1_wdata, rsp0_rdata, rsp1_rdata, sram_din0;
  logic [31:0] sram_dout0 = 32'h0;
  logic        req0_gnt, req1_gnt, rsp0_valid, rsp1_valid, init_done, sram_csb0, sram_web0;
  logic [31:0] mem [512];
  logic        seeded = 1'b0;
  int          tests = 0;
  int          fails = 0;
  typedef struct {
    logic v0; logic we0; logic [8:0] a0; logic [3:0] m0; logic [31:0] d0;
    logic v1; logic we1; logic [8:0] a1; logic [3:0] m1; logic [31:0] d1;
    logic g0; logic g1;
    logic r0v; logic [31:0] r0d; logic r1v; logic [31:0] r1d;
  } vec_t;
  vec_t vecs [21];

  always #5 clock = ~clock;

  sram_port_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wmask(req0_wmask), .req0_wdata(req0_wdata), .req0_gnt(req0_gnt),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wmask(req1_wmask), .req1_wdata(req1_wdata), .req1_gnt(req1_gnt),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .init_done(init_done),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  // macro model: garbage contents at power-up, masked byte writes, registered read data
  always @(posedge clock) begin
    if (!seeded) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'hBAD00000 | i;
      seeded <= 1'b1;
    end else if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
      end else sram_dout0 <= mem[sram_addr0];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_reqs();
    req0_valid = N; req0_we = N; req0_addr = '0; req0_wmask = '0; req0_wdata = '0;
    req1_valid = N; req1_we = N; req1_addr = '0; req1_wmask = '0; req1_wdata = '0;
  endtask

  task automatic chk_idle(input string name);
    chk(name, {sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0, req0_gnt, req1_gnt,
               rsp0_valid, rsp1_valid, init_done},
        {1'b1, 1'b1, 4'h0, 9'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic chk_fill(input string name, input int i);
    chk(name, {sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0, req0_gnt, req1_gnt, init_done},
        {1'b0, 1'b0, 4'hF, 9'(i), 32'h0, 1'b0, 1'b0, 1'b0});
  endtask

  initial begin
    vecs[0]  = '{Y,Y,9'h055,4'hF,32'hDEADBEEF, N,N,9'h0,4'h0,32'h0,       Y,N, N,32'h0,N,32'h0};
    vecs[1]  = '{N,N,9'h0,4'h0,32'h0,          Y,N,9'h055,4'h0,32'h0,     N,Y, N,32'h0,N,32'h0};
    vecs[2]  = '{N,N,9'h0,4'h0,32'h0,          N,N,9'h0,4'h0,32'h0,       N,N, N,32'h0,Y,32'hDEADBEEF};
    vecs[3]  = '{Y,Y,9'h010,4'hF,32'hAAAAAAAA, N,N,9'h0,4'h0,32'h0,       Y,N, N,32'h0,N,32'h0};
    vecs[4]  = '{Y,Y,9'h010,4'h5,32'h11223344, N,N,9'h0,4'h0,32'h0,       Y,N, N,32'h0,N,32'h0};
    vecs[5]  = '{Y,N,9'h010,4'h0,32'h0,        N,N,9'h0,4'h0,32'h0,       Y,N, N,32'h0,N,32'h0};
    vecs[6]  = '{N,N,9'h0,4'h0,32'h0,          Y,N,9'h1FF,4'h0,32'h0,     N,Y, Y,32'hAA22AA44,N,32'h0};
    vecs[7]  = '{Y,N,9'h055,4'h0,32'h0,        Y,N,9'h010,4'h0,32'h0,     Y,N, N,32'h0,Y,32'h0};
    vecs[8]  = '{Y,N,9'h055,4'h0,32'h0,        Y,N,9'h010,4'h0,32'h0,     N,Y, Y,32'hDEADBEEF,N,32'h0};
    vecs[9]  = '{Y,N,9'h055,4'h0,32'h0,        Y,N,9'h010,4'h0,32'h0,     Y,N, N,32'h0,Y,32'hAA22AA44};
    vecs[10] = '{Y,N,9'h055,4'h0,32'h0,        Y,N,9'h010,4'h0,32'h0,     N,Y, Y,32'hDEADBEEF,N,32'h0};
    vecs[11] = '{Y,N,9'h055,4'h0,32'h0,        Y,N,9'h010,4'h0,32'h0,     Y,N, N,32'h0,Y,32'hAA22AA44};
    vecs[12] = '{Y,N,9'h055,4'h0,32'h0,        Y,N,9'h010,4'h0,32'h0,     N,Y, Y,32'hDEADBEEF,N,32'h0};
    vecs[13] = '{N,N,9'h0,4'h0,32'h0,          N,N,9'h0,4'h0,32'h0,       N,N, N,32'h0,Y,32'hAA22AA44};
    vecs[14] = '{Y,N,9'h020,4'h0,32'h0,        N,N,9'h0,4'h0,32'h0,       Y,N, N,32'h0,N,32'h0};
    vecs[15] = '{Y,Y,9'h020,4'hF,32'h12345678, N,N,9'h0,4'h0,32'h0,       Y,N, Y,32'h0,N,32'h0};
    vecs[16] = '{Y,N,9'h020,4'h0,32'h0,        N,N,9'h0,4'h0,32'h0,       Y,N, N,32'h0,N,32'h0};
    vecs[17] = '{N,N,9'h0,4'h0,32'h0,          Y,Y,9'h021,4'hF,32'hCAFEF00D, N,Y, Y,32'h12345678,N,32'h0};
    vecs[18] = '{Y,N,9'h020,4'h0,32'h0,        Y,N,9'h021,4'h0,32'h0,     Y,N, N,32'h0,N,32'h0};
    vecs[19] = '{N,N,9'h0,4'h0,32'h0,          Y,N,9'h021,4'h0,32'h0,     N,Y, Y,32'h12345678,N,32'h0};
    vecs[20] = '{N,N,9'h0,4'h0,32'h0,          N,N,9'h0,4'h0,32'h0,       N,N, N,32'h0,Y,32'hCAFEF00D};
    clear_reqs();
    repeat (2) @(negedge clock);
    chk_idle("reset_state");
    req0_valid = Y; req1_valid = Y;
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    chk_idle("rst_idle_cycle");
    for (int i = 0; i < 512; i++) begin
      @(negedge clock);
      chk_fill($sformatf("fill_%0d", i), i);
      if (i == 511) clear_reqs();
    end
    @(negedge clock);
    chk("init_done_rise", {init_done, sram_csb0, req0_gnt, req1_gnt}, {1'b1, 1'b1, 1'b0, 1'b0});
    for (int k = 0; k < 21; k++) begin
      logic [8:0]  ea;
      logic [31:0] ed;
      logic [3:0]  em;
      logic        ew;
      @(posedge clock); #1;
      req0_valid = vecs[k].v0; req0_we = vecs[k].we0; req0_addr = vecs[k].a0;
      req0_wmask = vecs[k].m0; req0_wdata = vecs[k].d0;
      req1_valid = vecs[k].v1; req1_we = vecs[k].we1; req1_addr = vecs[k].a1;
      req1_wmask = vecs[k].m1; req1_wdata = vecs[k].d1;
      @(negedge clock);
      chk($sformatf("gnt_v%0d", k), {req0_gnt, req1_gnt}, {vecs[k].g0, vecs[k].g1});
      chk($sformatf("rsp_v%0d", k), {rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata},
          {vecs[k].r0v, vecs[k].r0d, vecs[k].r1v, vecs[k].r1d});
      ea = vecs[k].g0 ? vecs[k].a0 : vecs[k].g1 ? vecs[k].a1 : 9'h0;
      ed = vecs[k].g0 ? vecs[k].d0 : vecs[k].g1 ? vecs[k].d1 : 32'h0;
      em = vecs[k].g0 ? vecs[k].m0 : vecs[k].g1 ? vecs[k].m1 : 4'h0;
      ew = vecs[k].g0 ? !vecs[k].we0 : vecs[k].g1 ? !vecs[k].we1 : 1'b1;
      chk($sformatf("macro_v%0d", k), {sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0},
          {!(vecs[k].g0 | vecs[k].g1), ew, em, ea, ed});
    end
    @(posedge clock); #1;
    clear_reqs();
    req0_valid = Y; req0_addr = 9'h055;
    @(posedge clock); #1;
    clear_reqs();
    chk("pre_abort_rsp", {rsp0_valid, rsp0_rdata}, {1'b1, 32'hDEADBEEF});
    reset_n = 1'b0;
    #1 chk_idle("abort_mid_read");
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    chk_idle("rst_idle_after_read_abort");
    for (int i = 0; i <= 200; i++) @(negedge clock);
    chk_fill("fill_at_200", 200);
    reset_n = 1'b0;
    #1 chk_idle("abort_mid_fill");
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    chk_idle("rst_idle_after_fill_abort");
    @(negedge clock);
    chk_fill("fill_restart_0", 0);
    @(negedge clock);
    chk_fill("fill_restart_1", 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
